zbus_trap: RTL and testbench
============================

Name: zbus_trap

Overview:
- Synthesizable Z80 bus-cycle tracer inside the FPGA top level.
- Watches the delayed Z80 strobes, address and both data directions on fclk. Classifies each bus cycle and keeps a 4-deep cycle history.
- On the TR-DOS `INI`-from-ROM signature (`FETCH ED` at TRAP_ADDR, `FETCH A2`, `IORD`, `MWR` into 0000-3FFF) it emits a one-fclk NMI-set strobe.
- Sits downstream of the Z80 bus pins and upstream of the NMI logic (`set_nmi` input).

Parameters:
- TRAP_ADDR, 16'h3FEC, fetch address of the `ED` opcode that starts the signature.
- SYNC_STAGES, 2, depth of the synchronizer on each Z80 strobe (≥2).

Ports:
- fclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  asynchronous Z80 strobes.
- a  in  16  Z80 address.
- d_wr  in  8  data driven by the Z80.
- d_rd  in  8  data driven to the Z80 (d_pre_out).
- trap_ena  in  1  enables trap_stb generation.
- cyc_type  out  3  type of the last completed cycle: 0 FETCH, 1 MRD, 2 MWR, 3 IORD, 4 IOWR, 5 IACK, 7 none.
- cyc_stb  out  1  one-fclk pulse when a cycle completes.
- trap_stb  out  1  one-fclk pulse on signature match.
- trap_port  out  16  port address of the matched IORD.
- trap_wraddr  out  16  address of the matched MWR.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 except cyc_type=7.
  - History valid bits are cleared.
  - Synchronizers are set to 1 (inactive).
  - Reset mid-cycle discards the cycle in progress.
- Strobe synchronization:
  - The six strobes pass through SYNC_STAGES flops.
  - a, d_wr and d_rd are registered once per fclk, with no synchronizer. They are stable while the strobes are active.
- Classification on synchronized levels, first match wins:
  - FETCH = m1 & mreq & rd
  - MRD = !m1 & mreq & rd
  - MWR = mreq & wr
  - IORD = iorq & rd
  - IOWR = iorq & wr
  - IACK = m1 & iorq
  - Any other combination is idle. This covers refresh (mreq & rfsh, rd high) and T1 with mreq low but no rd/wr.
- Cycle FSM, states IDLE and ACTIVE:
  - IDLE→ACTIVE when the class becomes non-idle. The class is latched as cur_type.
  - While ACTIVE, every fclk the block captures a→cur_addr and data→cur_data. Data is d_rd for FETCH/MRD/IORD/IACK and d_wr for MWR/IOWR. The last sample before the end therefore wins.
  - ACTIVE→IDLE when the class becomes idle: the cycle completes.
  - ACTIVE with the class changing to a different non-idle class: the current cycle completes and a new one starts in the same fclk, with no IDLE state.
- Completion, in the completing fclk edge:
  - History shifts: h[3]←h[2]…, h[0]←{cur_type, cur_addr, cur_data, valid=1}.
  - cyc_stb=1 and cyc_type=cur_type, registered, so visible in the next fclk.
- Match: evaluated on the updated history, registered.
  - trap_stb is high exactly 1 fclk, the fclk after cyc_stb.
  - Conditions, all required:
    - h[3..0] all valid.
    - h[3] = FETCH, addr == TRAP_ADDR, data 8'hED.
    - h[2] = FETCH, data 8'hA2.
    - h[1] = IORD.
    - h[0] = MWR with addr[15:14] == 2'b00.
    - trap_ena=1.
  - On a match, trap_port←h[1].addr and trap_wraddr←h[0].addr, updated only on a match and held otherwise.
- trap_ena=0 suppresses trap_stb and the trap_* updates only; history keeps running.
- Back-to-back matches are impossible, since each needs 4 new cycles. The history is not cleared after a match.
- Latency from the Z80 strobe deassert pin to trap_stb: SYNC_STAGES+2 fclk.

Optional Feature:
- ZBUS_TRAP_COUNT_EN
- With it defined:
  - Adds output port trap_cnt (out, 16): a saturating count of trap_stb pulses. It resets to 0, stops at 16'hFFFF, and increments in the same fclk trap_stb is high.
  - Adds input trap_cnt_clr (in, 1): a synchronous clear that has priority over the increment.
- Without it: neither port nor counter exists; other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with strobes toggling -> cyc_type=7; cyc_stb, trap_stb, trap_port and trap_wraddr all 0.
- Signature with trap_ena=1:
  - Stimulus: fetch 3FEC/ED, fetch 3FED/A2, IORD port 1F7F, MWR 3C00, each fetch followed by a refresh.
  - Required: cyc_type sequence 0,0,3,2 with one cyc_stb each and no stb for the refreshes; one trap_stb, 1 fclk after the MWR cyc_stb; trap_port=1F7F; trap_wraddr=3C00.
- Same sequence, MWR to 4000 -> no trap_stb; trap_port and trap_wraddr unchanged.
- Same sequence with trap_ena=0 -> no trap_stb; then repeat with trap_ena=1 -> one trap_stb.
- MWR strobe idle then mreq low two fclk before wr low -> exactly one MWR completion, with data equal to d_wr in its last active fclk.
- ZBUS_TRAP_COUNT_EN: run 3 signatures -> trap_cnt=3. Pulse trap_cnt_clr together with a 4th trap_stb -> trap_cnt=0. Preload 16'hFFFF and trap again -> trap_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/zbus_trap.sv
// zbus_trap: Z80 bus-cycle tracer with a 4-deep cycle history and TR-DOS INI-from-ROM trap strobe.
// Optional macro ZBUS_TRAP_COUNT_EN adds a saturating trap counter (trap_cnt, trap_cnt_clr).
//
// state     | meaning
// ST_IDLE   | no bus cycle in progress on the synchronized strobes
// ST_ACTIVE | cycle of class cur_type_q in progress, address/data resampled every fclk

module zbus_trap #(
   parameter logic [15:0] TRAP_ADDR   = 16'h3FEC,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        iorq_n,
   input  logic        mreq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        rfsh_n,
   input  logic [15:0] a,
   input  logic [7:0]  d_wr,
   input  logic [7:0]  d_rd,
   input  logic        trap_ena,
`ifdef ZBUS_TRAP_COUNT_EN
   input  logic        trap_cnt_clr,
   output logic [15:0] trap_cnt,
`endif
   output logic [2:0]  cyc_type,
   output logic        cyc_stb,
   output logic        trap_stb,
   output logic [15:0] trap_port,
   output logic [15:0] trap_wraddr
);

   localparam logic [2:0] CT_FETCH = 3'd0;
   localparam logic [2:0] CT_MRD   = 3'd1;
   localparam logic [2:0] CT_MWR   = 3'd2;
   localparam logic [2:0] CT_IORD  = 3'd3;
   localparam logic [2:0] CT_IOWR  = 3'd4;
   localparam logic [2:0] CT_IACK  = 3'd5;
   localparam logic [2:0] CT_NONE  = 3'd7;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   typedef struct packed {
      logic        vld;
      logic [2:0]  typ;
      logic [15:0] addr;
      logic [7:0]  data;
   } hist_t;

   // Strobe order in each synchronizer word: iorq, mreq, rd, wr, m1, rfsh (all active-low).
   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [15:0] a_q;
   logic [7:0]  dwr_q;
   logic [7:0]  drd_q;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         a_q    <= '0;
         dwr_q  <= '0;
         drd_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n}};
         a_q    <= a;
         dwr_q  <= d_wr;
         drd_q  <= d_rd;
      end
   end

   logic iorq_s, mreq_s, rd_s, wr_s, m1_s, unused_rfsh_s;
   assign {iorq_s, mreq_s, rd_s, wr_s, m1_s, unused_rfsh_s} = ~sync_q[SYNC_STAGES-1];

   logic [2:0] cls;
   logic [7:0] cap_data;

   always_comb begin
      cls = CT_NONE;
      if (m1_s && mreq_s && rd_s)
         cls = CT_FETCH;
      else if (mreq_s && rd_s)
         cls = CT_MRD;
      else if (mreq_s && wr_s)
         cls = CT_MWR;
      else if (iorq_s && rd_s)
         cls = CT_IORD;
      else if (iorq_s && wr_s)
         cls = CT_IOWR;
      else if (m1_s && iorq_s)
         cls = CT_IACK;
   end

   assign cap_data = (cls == CT_MWR || cls == CT_IOWR) ? dwr_q : drd_q;

   state_t      state_q, state_d;
   logic [2:0]  cur_type_q, cur_type_d;
   logic [15:0] cur_addr_q, cur_addr_d;
   logic [7:0]  cur_data_q, cur_data_d;
   logic        complete;

   always_comb begin
      state_d    = state_q;
      cur_type_d = cur_type_q;
      cur_addr_d = cur_addr_q;
      cur_data_d = cur_data_q;
      complete   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cls != CT_NONE) begin
               state_d    = ST_ACTIVE;
               cur_type_d = cls;
               cur_addr_d = a_q;
               cur_data_d = cap_data;
            end
         end
         ST_ACTIVE: begin
            if (cls == CT_NONE) begin
               complete   = 1'b1;
               state_d    = ST_IDLE;
               cur_type_d = CT_NONE;
            end else begin
               // A class change closes the old cycle and opens the new one in the same fclk.
               complete   = (cls != cur_type_q);
               cur_type_d = cls;
               cur_addr_d = a_q;
               cur_data_d = cap_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   hist_t [3:0] hist_q, hist_d;
   logic        cyc_stb_q, cyc_stb_d;
   logic [2:0]  cyc_type_q, cyc_type_d;
   logic        trap_stb_q, trap_stb_d;
   logic [15:0] trap_port_q, trap_port_d;
   logic [15:0] trap_wraddr_q, trap_wraddr_d;
   logic        match;
   logic        fire;

   assign match = hist_q[3].vld && hist_q[2].vld && hist_q[1].vld && hist_q[0].vld
               && hist_q[3].typ == CT_FETCH && hist_q[3].addr == TRAP_ADDR
               && hist_q[3].data == 8'hED
               && hist_q[2].typ == CT_FETCH && hist_q[2].data == 8'hA2
               && hist_q[1].typ == CT_IORD
               && hist_q[0].typ == CT_MWR && hist_q[0].addr[15:14] == 2'b00;

   // Only the fclk right after a completion may fire, so a held history never re-triggers.
   assign fire = cyc_stb_q && trap_ena && match;

   logic unused_hist;
   assign unused_hist = ^{hist_q[2].addr, hist_q[1].data, hist_q[0].data};

   always_comb begin
      hist_d        = hist_q;
      cyc_stb_d     = 1'b0;
      cyc_type_d    = cyc_type_q;
      trap_stb_d    = fire;
      trap_port_d   = trap_port_q;
      trap_wraddr_d = trap_wraddr_q;
      if (complete) begin
         hist_d     = {hist_q[2:0], hist_t'{vld: 1'b1, typ: cur_type_q,
                                            addr: cur_addr_q, data: cur_data_q}};
         cyc_stb_d  = 1'b1;
         cyc_type_d = cur_type_q;
      end
      if (fire) begin
         trap_port_d   = hist_q[1].addr;
         trap_wraddr_d = hist_q[0].addr;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cur_type_q    <= CT_NONE;
         cur_addr_q    <= '0;
         cur_data_q    <= '0;
         hist_q        <= '0;
         cyc_stb_q     <= 1'b0;
         cyc_type_q    <= CT_NONE;
         trap_stb_q    <= 1'b0;
         trap_port_q   <= '0;
         trap_wraddr_q <= '0;
      end else begin
         state_q       <= state_d;
         cur_type_q    <= cur_type_d;
         cur_addr_q    <= cur_addr_d;
         cur_data_q    <= cur_data_d;
         hist_q        <= hist_d;
         cyc_stb_q     <= cyc_stb_d;
         cyc_type_q    <= cyc_type_d;
         trap_stb_q    <= trap_stb_d;
         trap_port_q   <= trap_port_d;
         trap_wraddr_q <= trap_wraddr_d;
      end
   end

   assign cyc_stb     = cyc_stb_q;
   assign cyc_type    = cyc_type_q;
   assign trap_stb    = trap_stb_q;
   assign trap_port   = trap_port_q;
   assign trap_wraddr = trap_wraddr_q;

`ifdef ZBUS_TRAP_COUNT_EN
   logic [15:0] trap_cnt_q;

   // Counts on the edge that raises trap_stb, so the new value appears alongside the pulse.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)
         trap_cnt_q <= '0;
      else if (trap_cnt_clr)
         trap_cnt_q <= '0;
      else if (fire && trap_cnt_q != 16'hFFFF)
         trap_cnt_q <= trap_cnt_q + 16'd1;
   end

   assign trap_cnt = trap_cnt_q;
`endif

endmodule

// File: tb/tb_zbus_trap.sv
// Directed bench for zbus_trap: drives Z80 bus cycles pin-by-pin and checks cycle strobes,
// classification, trap signature detection, latency and (when enabled) the trap counter.

module tb_zbus_trap;

   localparam int K_FETCH = 0;
   localparam int K_MRD   = 1;
   localparam int K_MWR   = 2;
   localparam int K_IORD  = 3;
   localparam int K_IOWR  = 4;
   localparam int K_IACK  = 5;

   logic        fclk = 1'b0;
   logic        rst_n;
   logic        iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n;
   logic [15:0] a;
   logic [7:0]  d_wr, d_rd;
   logic        trap_ena;
   logic [2:0]  cyc_type;
   logic        cyc_stb, trap_stb;
   logic [15:0] trap_port, trap_wraddr;
`ifdef ZBUS_TRAP_COUNT_EN
   logic        trap_cnt_clr;
   logic [15:0] trap_cnt;
`endif

   zbus_trap dut (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .iorq_n      (iorq_n),
      .mreq_n      (mreq_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m1_n        (m1_n),
      .rfsh_n      (rfsh_n),
      .a           (a),
      .d_wr        (d_wr),
      .d_rd        (d_rd),
      .trap_ena    (trap_ena),
`ifdef ZBUS_TRAP_COUNT_EN
      .trap_cnt_clr(trap_cnt_clr),
      .trap_cnt    (trap_cnt),
`endif
      .cyc_type    (cyc_type),
      .cyc_stb     (cyc_stb),
      .trap_stb    (trap_stb),
      .trap_port   (trap_port),
      .trap_wraddr (trap_wraddr)
   );

   always #5 fclk = ~fclk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc_n = 0;
   int         nlog = 0;
   logic [2:0] typ_log [256];
   int         ntrap = 0;
   int         trap_fol = 0;
   int         trap_cyc = 0;
   int         dea_cyc = 0;
   logic       prev_stb = 1'b0;
   logic [2:0] prev_type = 3'd7;

   always @(posedge fclk) cyc_n <= cyc_n + 1;

   always @(negedge fclk) begin
      if (rst_n) begin
         if (trap_stb) begin
            ntrap = ntrap + 1;
            trap_cyc = cyc_n;
            if (prev_stb && prev_type == 3'd2) trap_fol = trap_fol + 1;
         end
         if (cyc_stb && nlog < 256) begin
            typ_log[nlog] = cyc_type;
            nlog = nlog + 1;
         end
         prev_stb  = cyc_stb;
         prev_type = cyc_type;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(posedge fclk);
      #1;
   endtask

   task automatic bus_idle();
      iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
   endtask

   // One bus cycle; address and data stay stable well past the strobe release.
   task automatic bus(input int kind, input logic [15:0] addr, input logic [7:0] dat,
                      input bit late);
      a = addr;
      case (kind)
         K_FETCH: begin
            d_rd = 8'h00; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
            clk(2);
            d_rd = dat;
            clk(2);
            bus_idle();
            clk(1);
            mreq_n = 1'b0; rfsh_n = 1'b0;
            clk(2);
         end
         K_MRD:  begin d_rd = dat; mreq_n = 1'b0; rd_n = 1'b0; clk(3); end
         K_MWR: begin
            d_wr = 8'h5A; mreq_n = 1'b0;
            if (late) clk(2);
            wr_n = 1'b0;
            clk(2);
            d_wr = dat;
            clk(2);
         end
         K_IORD: begin d_rd = dat; iorq_n = 1'b0; rd_n = 1'b0; clk(3); end
         K_IOWR: begin d_wr = dat; iorq_n = 1'b0; wr_n = 1'b0; clk(3); end
         default: begin d_rd = dat; m1_n = 1'b0; iorq_n = 1'b0; clk(3); end
      endcase
      bus_idle();
      dea_cyc = cyc_n;
      clk(6);
   endtask

   task automatic sig(input logic [15:0] port, input logic [15:0] wraddr,
                      input logic [15:0] faddr, input bit late);
      bus(K_FETCH, faddr, 8'hED, 1'b0);
      bus(K_FETCH, faddr + 16'd1, 8'hA2, 1'b0);
      bus(K_IORD, port, 8'hFF, 1'b0);
      bus(K_MWR, wraddr, 8'h77, late);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0, f0, nmwr;
      bus_idle();
      rst_n = 1'b0; trap_ena = 1'b1; a = '0; d_wr = '0; d_rd = '0;
`ifdef ZBUS_TRAP_COUNT_EN
      trap_cnt_clr = 1'b0;
`endif
      clk(1);
      for (int i = 0; i < 6; i++) begin
         m1_n = i[0]; mreq_n = i[0]; rd_n = i[0]; a = 16'h3FEC;
         clk(1);
      end
      chk("rst_cyc_type", cyc_type, 3'd7);
      chk("rst_cyc_stb", cyc_stb, 1'b0);
      chk("rst_trap_stb", trap_stb, 1'b0);
      chk("rst_trap_port", trap_port, 16'h0000);
      chk("rst_trap_wraddr", trap_wraddr, 16'h0000);
      bus_idle();
      clk(1);
      rst_n = 1'b1;
      clk(4);

      // Full signature
      base = nlog; t0 = ntrap; f0 = trap_fol;
      sig(16'h1F7F, 16'h3C00, 16'h3FEC, 1'b0);
      chk("sig1_ncyc", nlog - base, 4);
      chk("sig1_type0", typ_log[base], 3'd0);
      chk("sig1_type1", typ_log[base+1], 3'd0);
      chk("sig1_type2", typ_log[base+2], 3'd3);
      chk("sig1_type3", typ_log[base+3], 3'd2);
      chk("sig1_ntrap", ntrap - t0, 1);
      chk("sig1_trap_after_mwr", trap_fol - f0, 1);
      chk("sig1_latency", trap_cyc - dea_cyc, 4);
      chk("sig1_port", trap_port, 16'h1F7F);
      chk("sig1_wraddr", trap_wraddr, 16'h3C00);

      // MWR outside 0000-3FFF
      base = nlog; t0 = ntrap;
      sig(16'h00FE, 16'h4000, 16'h3FEC, 1'b0);
      chk("hiwr_ncyc", nlog - base, 4);
      chk("hiwr_ntrap", ntrap - t0, 0);
      chk("hiwr_port", trap_port, 16'h1F7F);
      chk("hiwr_wraddr", trap_wraddr, 16'h3C00);

      // trap_ena low, then high
      trap_ena = 1'b0; t0 = ntrap;
      sig(16'h1234, 16'h0100, 16'h3FEC, 1'b0);
      chk("dis_ntrap", ntrap - t0, 0);
      chk("dis_port", trap_port, 16'h1F7F);
      chk("dis_wraddr", trap_wraddr, 16'h3C00);
      trap_ena = 1'b1; t0 = ntrap;
      sig(16'h1234, 16'h0100, 16'h3FEC, 1'b0);
      chk("ena_ntrap", ntrap - t0, 1);
      chk("ena_port", trap_port, 16'h1234);
      chk("ena_wraddr", trap_wraddr, 16'h0100);

      // Wrong fetch address
      t0 = ntrap;
      sig(16'h5555, 16'h2000, 16'h3FEE, 1'b0);
      chk("badaddr_ntrap", ntrap - t0, 0);
      chk("badaddr_port", trap_port, 16'h1234);

      // MWR with mreq asserted two fclk ahead of wr
      base = nlog; t0 = ntrap;
      sig(16'h2FFE, 16'h0042, 16'h3FEC, 1'b1);
      nmwr = 0;
      for (int i = 0; i < 4; i++) if (typ_log[base+i] == 3'd2) nmwr++;
      chk("late_ncyc", nlog - base, 4);
      chk("late_nmwr", nmwr, 1);
      chk("late_last_type", typ_log[base+3], 3'd2);
      chk("late_wr_data", dut.hist_q[0].data, 8'h77);
      chk("late_ntrap", ntrap - t0, 1);
      chk("late_wraddr", trap_wraddr, 16'h0042);

      // Remaining classes
      base = nlog;
      bus(K_MRD, 16'h8000, 8'h11, 1'b0);
      bus(K_IOWR, 16'h00FE, 8'h22, 1'b0);
      bus(K_IACK, 16'h0000, 8'hFF, 1'b0);
      chk("cls_ncyc", nlog - base, 3);
      chk("cls_mrd", typ_log[base], 3'd1);
      chk("cls_iowr", typ_log[base+1], 3'd4);
      chk("cls_iack", typ_log[base+2], 3'd5);

      // Direct MRD -> MWR class change with no idle gap
      base = nlog;
      a = 16'h5000; d_rd = 8'h33; mreq_n = 1'b0; rd_n = 1'b0;
      clk(3);
      rd_n = 1'b1; wr_n = 1'b0;
      clk(3);
      bus_idle();
      clk(6);
      chk("chg_ncyc", nlog - base, 2);
      chk("chg_first", typ_log[base], 3'd1);
      chk("chg_second", typ_log[base+1], 3'd2);

      // Reset mid-cycle discards the open cycle
      base = nlog;
      a = 16'h6000; mreq_n = 1'b0; rd_n = 1'b0;
      clk(4);
      rst_n = 1'b0;
      clk(1);
      bus_idle();
      clk(2);
      rst_n = 1'b1;
      clk(6);
      chk("midrst_ncyc", nlog - base, 0);
      chk("midrst_cyc_type", cyc_type, 3'd7);
      chk("midrst_port", trap_port, 16'h0000);

`ifdef ZBUS_TRAP_COUNT_EN
      chk("cnt_after_rst", trap_cnt, 16'd0);
      repeat (3) sig(16'h1F7F, 16'h3C00, 16'h3FEC, 1'b0);
      chk("cnt_three", trap_cnt, 16'd3);
      t0 = ntrap;
      trap_cnt_clr = 1'b1;
      sig(16'h1F7F, 16'h3C00, 16'h3FEC, 1'b0);
      trap_cnt_clr = 1'b0;
      clk(1);
      chk("cnt_clr_ntrap", ntrap - t0, 1);
      chk("cnt_clr", trap_cnt, 16'd0);
      force dut.trap_cnt_q = 16'hFFFF;
      clk(1);
      release dut.trap_cnt_q;
      t0 = ntrap;
      sig(16'h1F7F, 16'h3C00, 16'h3FEC, 1'b0);
      chk("cnt_sat_ntrap", ntrap - t0, 1);
      chk("cnt_sat", trap_cnt, 16'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
